// File: rtl/fwd_hazard_unit_n_pkg.sv
// rtl/fwd_hazard_unit_n_pkg.sv - shared types and helpers for the forwarding/hazard unit
//   FWD_RF      : forward select value meaning "use register file"
//   fsm_state_t : RUN / LU_STALL / MEM_WAIT / ERROR
//   sel_w(n)    : select width able to encode 0..n
package pnr_fwd_pkg;

  localparam int FWD_RF = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } fsm_state_t;

  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_n_fwd_select.sv
// rtl/fwd_hazard_unit_n_fwd_select.sv - priority forward-source match for one operand
//   rs_label      in  : operand register label
//   rd_label_stg  in  : rd per post-EX stage, stage 1 in LSBs
//   reg_wb_en_stg in  : write enable per stage
//   is_load_stg   in  : load flag per stage
//   fwd_sel       out : 0 = register file, k = stage k
//   fwd_ld        out : selected source carries load data
module fwd_select
  import pnr_fwd_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int NUM_STAGES = 2,
  localparam int SEL_W      = sel_w(NUM_STAGES)
) (
  input  logic [REG_ADDR_W-1:0]            rs_label,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] rd_label_stg,
  input  logic [NUM_STAGES-1:0]            reg_wb_en_stg,
  input  logic [NUM_STAGES-1:0]            is_load_stg,
  output logic [SEL_W-1:0]                 fwd_sel,
  output logic                             fwd_ld
);

  always_comb begin
    fwd_sel = SEL_W'(FWD_RF);
    fwd_ld  = 1'b0;
    // Walk oldest to youngest so the youngest matching producer is the last writer.
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (reg_wb_en_stg[k] && (rs_label != '0) &&
          (rd_label_stg[k*REG_ADDR_W +: REG_ADDR_W] == rs_label)) begin
        fwd_sel = SEL_W'(k + 1);
        fwd_ld  = is_load_stg[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit_n.sv
// rtl/fwd_hazard_unit_n.sv - N-stage forwarding, load-use hazard and memory-wait control
//   clk_i, rst_i (async, active-high)
//   rs1/rs2_label_id_i, rs1/rs2_label_ex_i, rd_label_ex_i, reg_wb_en_ex_i, is_load_ex_i
//   rd_label_stg_i, reg_wb_en_stg_i, is_load_stg_i : post-EX stages, stage 1 in LSBs
//   mem_ready_i, flush_i
//   forward_a/b_o, forward_a/b_ld_o : forward select and load-data tag per operand
//   stall_o, mem_stall_o, mem_timeout_o, stall_cnt_o
module fwd_hazard_unit_n
  import pnr_fwd_pkg::*;
#(
  parameter  int REG_ADDR_W       = 5,
  parameter  int NUM_STAGES       = 2,
  parameter  int LOAD_READY_STAGE = 2,
  parameter  int MEM_TIMEOUT      = 64,
  parameter  int CNT_W            = 16,
  localparam int SEL_W            = sel_w(NUM_STAGES)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [REG_ADDR_W-1:0]            rs1_label_id_i,
  input  logic [REG_ADDR_W-1:0]            rs2_label_id_i,
  input  logic [REG_ADDR_W-1:0]            rs1_label_ex_i,
  input  logic [REG_ADDR_W-1:0]            rs2_label_ex_i,
  input  logic [REG_ADDR_W-1:0]            rd_label_ex_i,
  input  logic                             reg_wb_en_ex_i,
  input  logic                             is_load_ex_i,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] rd_label_stg_i,
  input  logic [NUM_STAGES-1:0]            reg_wb_en_stg_i,
  input  logic [NUM_STAGES-1:0]            is_load_stg_i,
  input  logic                             mem_ready_i,
  input  logic                             flush_i,
  output logic [SEL_W-1:0]                 forward_a_o,
  output logic [SEL_W-1:0]                 forward_b_o,
  output logic                             forward_a_ld_o,
  output logic                             forward_b_ld_o,
  output logic                             stall_o,
  output logic                             mem_stall_o,
  output logic                             mem_timeout_o,
  output logic [CNT_W-1:0]                 stall_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  fsm_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              hz;
  logic              mem_cond;
  logic              err;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_STAGES(NUM_STAGES)) u_fwd_a (
    .rs_label      (rs1_label_ex_i),
    .rd_label_stg  (rd_label_stg_i),
    .reg_wb_en_stg (reg_wb_en_stg_i),
    .is_load_stg   (is_load_stg_i),
    .fwd_sel       (forward_a_o),
    .fwd_ld        (forward_a_ld_o)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_STAGES(NUM_STAGES)) u_fwd_b (
    .rs_label      (rs2_label_ex_i),
    .rd_label_stg  (rd_label_stg_i),
    .reg_wb_en_stg (reg_wb_en_stg_i),
    .is_load_stg   (is_load_stg_i),
    .fwd_sel       (forward_b_o),
    .fwd_ld        (forward_b_ld_o)
  );

  function automatic logic id_match(input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rd);
    return (rs != '0) && (rs == rd);
  endfunction

  // A load is a hazard while its data is not yet forwardable: in EX, or in any
  // post-EX stage that precedes LOAD_READY_STAGE.
  always_comb begin
    hz = 1'b0;
    if (reg_wb_en_ex_i && is_load_ex_i &&
        (id_match(rs1_label_id_i, rd_label_ex_i) || id_match(rs2_label_id_i, rd_label_ex_i)))
      hz = 1'b1;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if ((k + 1 < LOAD_READY_STAGE) && reg_wb_en_stg_i[k] && is_load_stg_i[k] &&
          (id_match(rs1_label_id_i, rd_label_stg_i[k*REG_ADDR_W +: REG_ADDR_W]) ||
           id_match(rs2_label_id_i, rd_label_stg_i[k*REG_ADDR_W +: REG_ADDR_W])))
        hz = 1'b1;
    end
  end

  assign mem_cond      = is_load_stg_i[0] & ~mem_ready_i;
  assign err           = (state == ERROR);
  assign mem_stall_o   = (mem_cond | err) & ~rst_i;
  // A full-pipeline freeze already holds the younger instructions, so no bubble.
  assign stall_o       = hz & ~flush_i & ~mem_stall_o & ~rst_i;
  assign mem_timeout_o = err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN, LU_STALL: begin
        wait_cnt_nxt = '0;
        if (mem_cond)
          state_nxt = MEM_WAIT;
        else if (hz && !flush_i)
          state_nxt = LU_STALL;
        else
          state_nxt = RUN;
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if ((stall_o | mem_stall_o) && !(&stall_cnt_o))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

  // Load data from a stage before it is ready must never be consumed un-stalled.
  a_no_early_load: assert property (@(posedge clk_i) disable iff (rst_i)
    !(!stall_o &&
      ((forward_a_ld_o && forward_a_o != '0 && int'(forward_a_o) < LOAD_READY_STAGE) ||
       (forward_b_ld_o && forward_b_o != '0 && int'(forward_b_o) < LOAD_READY_STAGE))));

endmodule
